// File: rtl/multi_operand_sum_using_fifos_and_double_buffer.sv
`default_nettype none
// ============================================================================
// Module   : multi_operand_sum_using_fifos_and_double_buffer
// Purpose  : n_inputs valid/ready operand streams, each buffered in a FIFO,
//            summed in lockstep into a two-entry double-buffered output.
// Revision : 1.0 - initial release
// ============================================================================
module multi_operand_sum_using_fifos_and_double_buffer #(
    parameter int width    = 8,
    parameter int depth    = 10,
    parameter int n_inputs = 3,
    parameter int saturate = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [n_inputs-1:0]        in_valid,
    output logic [n_inputs-1:0]        in_ready,
    input  logic [n_inputs*width-1:0]  in_data,
    output logic                       sum_valid,
    input  logic                       sum_ready,
    output logic [width-1:0]           sum_data,
    output logic                       sum_overflow
);

    localparam int c_ptr_w = (depth > 1) ? $clog2(depth) : 1;
    localparam int c_cnt_w = $clog2(depth + 1);
    localparam int c_sum_w = width + $clog2(n_inputs);

    logic [n_inputs-1:0]            w_full;
    logic [n_inputs-1:0]            w_not_empty;
    logic [n_inputs-1:0]            w_push;
    logic [n_inputs-1:0][width-1:0] w_head;
    logic                           w_fire;
    logic                           r_up_ready;

    // Every channel pops on the same fire, so channels can never slip.
    assign w_fire   = (&w_not_empty) & r_up_ready;
    assign in_ready = ~w_full;

    for (genvar i = 0; i < n_inputs; i++) begin : g_fifo
        logic [width-1:0]   r_mem [depth];
        logic [c_ptr_w-1:0] r_wr_ptr;
        logic [c_ptr_w-1:0] r_rd_ptr;
        logic [c_cnt_w-1:0] r_count;

        assign w_full[i]      = (r_count == c_cnt_w'(depth));
        assign w_not_empty[i] = (r_count != '0);
        assign w_push[i]      = in_valid[i] & ~w_full[i];
        assign w_head[i]      = r_mem[r_rd_ptr];

        always_ff @(posedge clk) begin
            if (w_push[i]) begin
                r_mem[r_wr_ptr] <= in_data[i*width +: width];
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push[i]) begin
                    r_wr_ptr <= (r_wr_ptr == c_ptr_w'(depth - 1)) ? '0 : r_wr_ptr + 1'b1;
                end
                if (w_fire) begin
                    r_rd_ptr <= (r_rd_ptr == c_ptr_w'(depth - 1)) ? '0 : r_rd_ptr + 1'b1;
                end
                case ({w_push[i], w_fire})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    logic [c_sum_w-1:0] w_full_sum;
    logic               w_overflow;
    logic [width-1:0]   w_data;

    always_comb begin
        w_full_sum = '0;
        for (int i = 0; i < n_inputs; i++) begin
            w_full_sum = w_full_sum + c_sum_w'(w_head[i]);
        end
    end

    assign w_overflow = |w_full_sum[c_sum_w-1:width];
    assign w_data     = ((saturate != 0) && w_overflow) ? {width{1'b1}} : w_full_sum[width-1:0];

    // Entry 0 always holds the oldest result and drives the outputs directly.
    logic [width:0] r_e0;
    logic [width:0] r_e1;
    logic           r_e0_v;
    logic           r_e1_v;
    logic [width:0] w_e0_n;
    logic [width:0] w_e1_n;
    logic           w_e0_v_n;
    logic           w_e1_v_n;
    logic           w_read;

    assign w_read = r_e0_v & sum_ready;

    always_comb begin
        w_e0_n   = r_e0;
        w_e1_n   = r_e1;
        w_e0_v_n = r_e0_v;
        w_e1_v_n = r_e1_v;
        if (w_read) begin
            if (r_e1_v) begin
                w_e0_n   = r_e1;
                w_e1_v_n = 1'b0;
            end else begin
                w_e0_v_n = 1'b0;
            end
        end
        if (w_fire) begin
            if (!w_e0_v_n) begin
                w_e0_n   = {w_overflow, w_data};
                w_e0_v_n = 1'b1;
            end else begin
                w_e1_n   = {w_overflow, w_data};
                w_e1_v_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_e0       <= '0;
            r_e1       <= '0;
            r_e0_v     <= 1'b0;
            r_e1_v     <= 1'b0;
            r_up_ready <= 1'b1;
        end else begin
            r_e0       <= w_e0_n;
            r_e1       <= w_e1_n;
            r_e0_v     <= w_e0_v_n;
            r_e1_v     <= w_e1_v_n;
            r_up_ready <= ~(w_e0_v_n & w_e1_v_n);
        end
    end

    assign sum_valid    = r_e0_v;
    assign sum_data     = r_e0[width-1:0];
    assign sum_overflow = r_e0[width];

endmodule
`default_nettype wire

// File: tb/tb_multi_operand_sum_using_fifos_and_double_buffer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_multi_operand_sum_using_fifos_and_double_buffer
// Purpose  : directed self-checking bench; wrap and saturate instances share stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_operand_sum_using_fifos_and_double_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  in_valid = '0;
    logic [23:0] in_data = '0;
    logic        sum_ready = 1'b1;
    logic [2:0]  in_ready, in_ready_s;
    logic        sum_valid, sum_valid_s;
    logic [7:0]  sum_data, sum_data_s;
    logic        sum_overflow, sum_overflow_s;

    int n_checks = 0;
    int n_pass   = 0;

    multi_operand_sum_using_fifos_and_double_buffer #(
        .width(8), .depth(10), .n_inputs(3), .saturate(0)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .sum_valid(sum_valid), .sum_ready(sum_ready),
        .sum_data(sum_data), .sum_overflow(sum_overflow)
    );

    multi_operand_sum_using_fifos_and_double_buffer #(
        .width(8), .depth(10), .n_inputs(3), .saturate(1)
    ) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_data(in_data), .sum_valid(sum_valid_s), .sum_ready(sum_ready),
        .sum_data(sum_data_s), .sum_overflow(sum_overflow_s)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_all(input int a, input int b, input int c);
        in_valid = 3'b111;
        in_data  = {8'(c), 8'(b), 8'(a)};
        next_cycle();
        in_valid = '0;
    endtask

    // Scoreboard: k-th result is the sum of the k-th accepted element of each channel.
    int cq0[$], cq1[$], cq2[$], expq[$];
    logic       held = 1'b0;
    logic [7:0] held_data;
    int         n_out = 0;

    task automatic monitor();
        int e;
        if (in_valid[0] && in_ready[0]) cq0.push_back(int'(in_data[7:0]));
        if (in_valid[1] && in_ready[1]) cq1.push_back(int'(in_data[15:8]));
        if (in_valid[2] && in_ready[2]) cq2.push_back(int'(in_data[23:16]));
        while (cq0.size() > 0 && cq1.size() > 0 && cq2.size() > 0)
            expq.push_back(cq0.pop_front() + cq1.pop_front() + cq2.pop_front());
        if (held) check("hold_stable", sum_data, held_data);
        if (sum_valid && sum_ready) begin
            n_out++;
            if (expq.size() == 0) begin
                check("rnd_extra_result", 1, 0);
            end else begin
                e = expq.pop_front();
                check("rnd_data", sum_data, e % 256);
                check("rnd_ovf", sum_overflow, (e > 255) ? 1 : 0);
                check("rnd_sat_data", sum_data_s, (e > 255) ? 255 : e);
            end
        end
        held      = sum_valid && !sum_ready;
        held_data = sum_data;
    endtask

    initial begin
        int first_k;
        int res[$];
        int acc[3];
        int v0[3] = '{1, 2, 3};
        int v1[3] = '{10, 20, 30};
        int v2[3] = '{100, 200, 5};
        int burst_out;

        // Reset and idle
        sum_ready = 1'b1;
        @(negedge clk);
        check("reset_in_ready", in_ready, 3'b111);
        check("reset_sum_valid", sum_valid, 0);
        next_cycle();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("idle_sum_valid", sum_valid, 0);
            check("idle_sum_data", sum_data, 0);
            check("idle_sum_ovf", sum_overflow, 0);
            check("idle_in_ready", in_ready, 3'b111);
            next_cycle();
        end

        // Basic sum: valid exactly two cycles after the handshake
        drive_all(10, 20, 30);
        @(negedge clk);
        check("lat_t1_not_valid", sum_valid, 0);
        @(negedge clk);
        check("lat_t2_valid", sum_valid, 1);
        check("sum_60", sum_data, 60);
        check("sum_60_ovf", sum_overflow, 0);
        next_cycle();

        // Overflow: 350 wraps to 94 or clamps to 255
        drive_all(200, 100, 50);
        @(negedge clk);
        @(negedge clk);
        check("ovf_valid", sum_valid, 1);
        check("ovf_wrap_data", sum_data, 94);
        check("ovf_wrap_flag", sum_overflow, 1);
        check("ovf_sat_data", sum_data_s, 255);
        check("ovf_sat_flag", sum_overflow_s, 1);
        next_cycle();
        next_cycle();

        // Skewed arrival
        first_k = -1;
        for (int k = 0; k < 17; k++) begin
            in_valid = '0;
            if (k <= 2)            begin in_valid[0] = 1'b1; in_data[7:0]   = 8'(v0[k]);      end
            if (k >= 5 && k <= 7)  begin in_valid[1] = 1'b1; in_data[15:8]  = 8'(v1[k-5]);    end
            if (k >= 10 && k <= 12) begin in_valid[2] = 1'b1; in_data[23:16] = 8'(v2[k-10]);  end
            @(negedge clk);
            if (sum_valid) begin
                if (first_k < 0) first_k = k;
                res.push_back(int'(sum_data));
            end
            next_cycle();
        end
        in_valid = '0;
        check("skew_first_cycle", first_k, 12);
        check("skew_count", res.size(), 3);
        if (res.size() == 3) begin
            check("skew_r0", res[0], 111);
            check("skew_r1", res[1], 222);
            check("skew_r2", res[2], 38);
        end

        // Backpressure: 10 per FIFO plus 2 in the double buffer
        sum_ready = 1'b0;
        acc = '{0, 0, 0};
        for (int k = 0; k < 20; k++) begin
            in_valid = 3'b111;
            for (int i = 0; i < 3; i++) in_data[i*8 +: 8] = 8'((acc[i] + 1) * (i + 1));
            @(negedge clk);
            for (int i = 0; i < 3; i++) if (in_ready[i]) acc[i]++;
            next_cycle();
        end
        in_valid = '0;
        @(negedge clk);
        check("bp_acc0", acc[0], 12);
        check("bp_acc1", acc[1], 12);
        check("bp_acc2", acc[2], 12);
        check("bp_in_ready_low", in_ready, 0);
        check("bp_sum_valid", sum_valid, 1);
        check("bp_sum_held", sum_data, 6);
        next_cycle();
        sum_ready = 1'b1;
        res.delete();
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (sum_valid) res.push_back(int'(sum_data));
            next_cycle();
        end
        check("drain_count", res.size(), 12);
        for (int j = 0; j < res.size() && j < 12; j++) check("drain_value", res[j], 6 * (j + 1));
        @(negedge clk);
        check("drain_in_ready", in_ready, 3'b111);
        next_cycle();

        // Reset mid-stream with entries queued
        sum_ready = 1'b0;
        for (int k = 0; k < 4; k++) drive_all(1 + k, 2, 3);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_sum_valid", sum_valid, 0);
        check("midrst_in_ready", in_ready, 3'b111);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("postrst_sum_valid", sum_valid, 0);
        next_cycle();
        sum_ready = 1'b1;
        drive_all(7, 8, 9);
        @(negedge clk);
        @(negedge clk);
        check("postrst_valid", sum_valid, 1);
        check("postrst_data", sum_data, 24);
        next_cycle();
        next_cycle();

        // Random valid/ready against the scoreboard
        for (int k = 0; k < 400; k++) begin
            in_valid  = 3'($urandom_range(0, 7));
            sum_ready = ($urandom_range(0, 3) != 0);
            in_data   = 24'($urandom);
            @(negedge clk);
            monitor();
            next_cycle();
        end
        // All-ready burst: one result per cycle once the pipe is full
        burst_out = 0;
        for (int k = 0; k < 20; k++) begin
            in_valid  = 3'b111;
            sum_ready = 1'b1;
            in_data   = 24'($urandom);
            @(negedge clk);
            if (k >= 10 && sum_valid) burst_out++;
            monitor();
            next_cycle();
        end
        check("burst_throughput", burst_out, 10);
        in_valid = '0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            monitor();
            next_cycle();
        end
        check("rnd_all_drained", expq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
